// File: rtl/retospect_bs_loader.sv
// Byte-stream configuration loader for the neurochip clockbox/CNB chain.
// Shifts bytes LSB-first, collects readback, then pulses reset_nn.
module retospect_bs_loader #(
  parameter int CHAIN_LEN     = 523,
  parameter int NN_RST_CYCLES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       abort,
  input  logic [7:0] din,
  input  logic       din_valid,
  output logic       din_ready,
  output logic       config_en,
  output logic       bs_in,
  input  logic       bs_out,
  output logic       reset_nn,
  output logic [7:0] rd_data,
  output logic       rd_valid,
  output logic       busy,
  output logic       done
);

  localparam int RW = $clog2(CHAIN_LEN + 1);
  localparam int NW = $clog2(NN_RST_CYCLES + 1);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_BYTE,
    SHIFT,
    NN_RST,
    DONE
  } state_t;

  state_t        state;
  logic [RW-1:0] remaining;
  logic [3:0]    byte_bits;
  logic [7:0]    shreg;
  logic [7:0]    col;
  logic [2:0]    col_cnt;
  logic [NW-1:0] nn_cnt;
  logic [7:0]    col_next;
  logic          last_bit;

  assign col_next  = col | (8'(bs_out) << col_cnt);
  assign last_bit  = (remaining == RW'(1));

  assign din_ready = (state == WAIT_BYTE);
  assign config_en = (state == SHIFT);
  assign bs_in     = config_en & shreg[0];
  assign reset_nn  = (state == NN_RST);
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      remaining <= '0;
      byte_bits <= '0;
      shreg     <= '0;
      col       <= '0;
      col_cnt   <= '0;
      nn_cnt    <= '0;
      rd_data   <= '0;
      rd_valid  <= 1'b0;
    end else begin
      rd_valid <= 1'b0;
      if (abort && state != IDLE) begin
        // partial readback byte is dropped
        state   <= IDLE;
        col     <= '0;
        col_cnt <= '0;
      end else begin
        unique case (state)
          IDLE: begin
            if (start && !abort) begin
              state     <= WAIT_BYTE;
              remaining <= RW'(CHAIN_LEN);
            end
          end
          WAIT_BYTE: begin
            if (din_valid) begin
              shreg     <= din;
              byte_bits <= (32'(remaining) >= 32'd8) ? 4'd8 : 4'(remaining);
              state     <= SHIFT;
            end
          end
          SHIFT: begin
            shreg     <= shreg >> 1;
            remaining <= remaining - RW'(1);
            byte_bits <= byte_bits - 4'd1;
            if (col_cnt == 3'd7 || last_bit) begin
              rd_data  <= col_next;
              rd_valid <= 1'b1;
              col      <= '0;
              col_cnt  <= '0;
            end else begin
              col     <= col_next;
              col_cnt <= col_cnt + 3'd1;
            end
            if (byte_bits == 4'd1) begin
              state <= last_bit ? NN_RST : WAIT_BYTE;
            end
            nn_cnt <= '0;
          end
          NN_RST: begin
            if (nn_cnt == NW'(NN_RST_CYCLES - 1)) begin
              state <= DONE;
            end else begin
              nn_cnt <= nn_cnt + NW'(1);
            end
          end
          DONE: state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_retospect_bs_loader.sv
// Directed bench for retospect_bs_loader: short chain plus
// a default-length chain instance.
module tb_retospect_bs_loader;

  logic       clk = 1'b0;
  logic       reset;
  logic       start, abort, din_valid, bs_out;
  logic [7:0] din;
  logic       din_ready, config_en, bs_in, reset_nn, rd_valid, busy, done;
  logic [7:0] rd_data;

  logic       start_b, din_valid_b;
  logic [7:0] din_b;
  logic       din_ready_b, config_en_b, bs_in_b, reset_nn_b;
  logic       rd_valid_b, busy_b, done_b;
  logic [7:0] rd_data_b;

  int tests = 0;
  int fails = 0;

  int         cen, rn, dn;
  logic [15:0] bits;
  logic [7:0] rd_q[$];
  logic [9:0] pat = 10'b01_1001_0110;

  int         cen_b, rdn_b;
  logic [7:0] rd_last_b;

  always #5 clk = ~clk;

  retospect_bs_loader #(.CHAIN_LEN(10), .NN_RST_CYCLES(2)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .din(din), .din_valid(din_valid), .din_ready(din_ready),
    .config_en(config_en), .bs_in(bs_in), .bs_out(bs_out),
    .reset_nn(reset_nn), .rd_data(rd_data), .rd_valid(rd_valid),
    .busy(busy), .done(done)
  );

  retospect_bs_loader dut_b (
    .clk(clk), .reset(reset), .start(start_b), .abort(1'b0),
    .din(din_b), .din_valid(din_valid_b), .din_ready(din_ready_b),
    .config_en(config_en_b), .bs_in(bs_in_b), .bs_out(1'b1),
    .reset_nn(reset_nn_b), .rd_data(rd_data_b), .rd_valid(rd_valid_b),
    .busy(busy_b), .done(done_b)
  );

  // fabric model: present pattern bit for the upcoming shift
  always @(negedge clk) begin
    if (config_en) begin
      if (cen < 16) bits[cen] = bs_in;
      bs_out = pat[cen % 10];
      cen++;
    end
    if (reset_nn) rn++;
    if (done) dn++;
    if (rd_valid) rd_q.push_back(rd_data);
    if (config_en_b) cen_b++;
    if (rd_valid_b) begin
      rdn_b++;
      rd_last_b = rd_data_b;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    cen = 0;
    rn = 0;
    dn = 0;
    bits = '0;
    rd_q.delete();
  endtask

  task automatic start_load();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    while (!din_ready && n < 40) begin
      tick();
      n++;
    end
    chk("ready_timeout", 32'(n < 40), 32'd1);
    din = b;
    din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done && n < 200) begin
      tick();
      n++;
    end
    chk("done_timeout", 32'(n < 200), 32'd1);
    tick();
  endtask

  initial begin
    int n;
    logic bad;
    reset = 1'b1;
    start = 0; abort = 0; din_valid = 0; din = 0; bs_out = 0;
    start_b = 0; din_valid_b = 0; din_b = 0;
    cen = 0; rn = 0; dn = 0; bits = 0; cen_b = 0; rdn_b = 0;
    rd_last_b = 0;
    repeat (3) tick();
    chk("rst_busy", 32'(busy), 0);
    chk("rst_outs", {config_en, bs_in, reset_nn, rd_valid, done, din_ready},
        0);
    chk("rst_rd_data", 32'(rd_data), 0);
    reset = 1'b0;
    tick();

    // basic load with readback pattern
    clr();
    start_load();
    chk("busy_after_start", 32'(busy), 1);
    send_byte(8'hA5);
    send_byte(8'h03);
    wait_done();
    chk("cen_cycles", 32'(cen), 10);
    chk("bs_in_seq", 32'(bits[9:0]), 32'h3A5);
    chk("reset_nn_cycles", 32'(rn), 2);
    chk("done_pulses", 32'(dn), 1);
    chk("rd_count", 32'(rd_q.size()), 2);
    if (rd_q.size() == 2) begin
      chk("rd_byte0", 32'(rd_q[0]), 32'h96);
      chk("rd_byte1", 32'(rd_q[1]), 32'h01);
    end
    chk("busy_end", 32'(busy), 0);

    // stall in WAIT_BYTE
    clr();
    start_load();
    bad = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (config_en || !din_ready) bad = 1'b1;
      tick();
    end
    chk("stall_hold", 32'(bad), 0);
    chk("stall_ready", 32'(din_ready), 1);
    chk("stall_cen", 32'(cen), 0);
    send_byte(8'hA5);
    send_byte(8'h03);
    wait_done();
    chk("stall_cen_total", 32'(cen), 10);

    // abort after four shifted bits
    clr();
    start_load();
    send_byte(8'hA5);
    repeat (3) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_busy", 32'(busy), 0);
    chk("abort_cen_low", 32'(config_en), 0);
    repeat (12) tick();
    chk("abort_cen", 32'(cen), 4);
    chk("abort_no_nn", 32'(rn), 0);
    chk("abort_no_done", 32'(dn), 0);
    chk("abort_no_rd", 32'(rd_q.size()), 0);

    clr();
    start_load();
    send_byte(8'hA5);
    send_byte(8'h03);
    wait_done();
    chk("reload_cen", 32'(cen), 10);
    chk("reload_done", 32'(dn), 1);
    chk("reload_rd", 32'(rd_q.size()), 2);

    // start while shifting is ignored
    clr();
    start_load();
    send_byte(8'hA5);
    start = 1'b1;
    repeat (3) tick();
    start = 1'b0;
    send_byte(8'h03);
    wait_done();
    chk("midstart_cen", 32'(cen), 10);
    chk("midstart_done", 32'(dn), 1);
    chk("midstart_seq", 32'(bits[9:0]), 32'h3A5);

    // start with abort in IDLE
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    chk("sa_busy", 32'(busy), 0);
    chk("sa_ready", 32'(din_ready), 0);

    // default-length chain, 66 bytes
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    bad = 1'b0;
    for (int k = 0; k < 66; k++) begin
      n = 0;
      while (!din_ready_b && n < 40) begin
        tick();
        n++;
      end
      if (n >= 40) bad = 1'b1;
      din_b = 8'(k);
      din_valid_b = 1'b1;
      tick();
      din_valid_b = 1'b0;
    end
    chk("big_ready_timeout", 32'(bad), 0);
    n = 0;
    while (!done_b && n < 200) begin
      tick();
      n++;
    end
    chk("big_done_timeout", 32'(n < 200), 1);
    tick();
    chk("big_cen", 32'(cen_b), 523);
    chk("big_rd_count", 32'(rdn_b), 66);
    chk("big_rd_last", 32'(rd_last_b), 32'h07);
    chk("big_busy", 32'(busy_b), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
